// File: rtl/axis_packet_fifo.sv
// rtl/axis_packet_fifo.sv - AXI4-Stream FIFO with optional store-and-forward packet mode
//
// Purpose:
//    Buffers an AXI4-Stream link of DATA_W bits with TKEEP/TLAST sideband.
//    PACKET_MODE=0 forwards beats as soon as they are stored (cut-through).
//    PACKET_MODE=1 only presents beats once a whole packet is stored, unless
//    a packet larger than the FIFO fills it, in which case it drains in
//    cut-through until that packet's TLAST leaves.
//
// Ports:
//    aclk, areset          clock, asynchronous active-high reset
//    s_axis_*              input stream (tdata, tkeep, tlast, tvalid, tready)
//    m_axis_*              output stream (tdata, tkeep, tlast, tvalid, tready)
//    occupancy             beats stored, including the one on m_axis
//    pkt_count             TLAST beats currently stored

module axis_packet_fifo #(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 16,
   parameter int PACKET_MODE = 0
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic [DATA_W-1:0]          s_axis_tdata,
   input  logic [DATA_W/8-1:0]        s_axis_tkeep,
   input  logic                       s_axis_tlast,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   output logic [DATA_W-1:0]          m_axis_tdata,
   output logic [DATA_W/8-1:0]        m_axis_tkeep,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [$clog2(DEPTH):0]     pkt_count
);

   localparam int  KW  = DATA_W / 8;
   localparam int  AW  = $clog2(DEPTH);
   localparam int  PW  = AW + 1;
   localparam int  EW  = DATA_W + KW + 1;
   localparam bit  CUT = (PACKET_MODE == 0);

   // Entry layout: {tdata, tkeep, tlast}
   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] mem_d [DEPTH];

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] pkt_q, pkt_d;
   logic [EW-1:0] out_q, out_d;
   logic          out_valid_q, out_valid_d;
   logic          ovf_q, ovf_d;
   logic          rdy_en_q, rdy_en_d;

   logic [PW-1:0] occ;
   logic          full;
   logic          push;
   logic          pop;
   logic [EW-1:0] in_entry;

   // Status and handshakes decode from registered state only.
   always_comb begin
      occ           = wptr_q - rptr_q;
      full          = (occ == PW'(DEPTH));
      // rdy_en_q keeps tready low during reset and lets it rise on the
      // first edge after release.
      s_axis_tready = rdy_en_q & ~full;
      m_axis_tvalid = out_valid_q & (CUT | (pkt_q != '0) | ovf_q);
      push          = s_axis_tvalid & s_axis_tready;
      pop           = m_axis_tvalid & m_axis_tready;
      in_entry      = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
   end

   assign m_axis_tdata = out_q[EW-1 -: DATA_W];
   assign m_axis_tkeep = out_q[KW:1];
   assign m_axis_tlast = out_q[0];
   assign occupancy    = occ;
   assign pkt_count    = pkt_q;

   // The output register is a copy of the entry at rptr; that entry stays
   // in memory until popped, so occupancy naturally includes it.
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wptr_q[AW-1:0]] = in_entry;
      end

      wptr_d      = wptr_q + PW'(push);
      rptr_d      = rptr_q + PW'(pop);
      out_valid_d = (wptr_d != rptr_d);

      // Refill the output stage with the new head whenever it is empty or
      // being consumed. If the new head is the beat being written this very
      // cycle, take it straight from the input for single-cycle latency.
      out_d = out_q;
      if ((!out_valid_q || pop) && out_valid_d) begin
         if (rptr_d == wptr_q) begin
            out_d = in_entry;
         end else begin
            out_d = mem_q[rptr_d[AW-1:0]];
         end
      end

      pkt_d = pkt_q + PW'(push & s_axis_tlast) - PW'(pop & m_axis_tlast);

      // An oversized packet fills the FIFO with no TLAST stored; draining it
      // in cut-through is the only way forward.
      ovf_d = ovf_q;
      if (!CUT && full && (pkt_q == '0)) begin
         ovf_d = 1'b1;
      end
      if (pop && m_axis_tlast) begin
         ovf_d = 1'b0;
      end

      rdy_en_d = 1'b1;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         pkt_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         rdy_en_q    <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         pkt_q       <= pkt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
         rdy_en_q    <= rdy_en_d;
      end
   end

   // Storage contents need no reset; the pointers define what is valid.
   always_ff @(posedge aclk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb/tb_axis_packet_fifo.sv - self-checking bench for axis_packet_fifo

module tb_axis_packet_fifo;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;

   int total = 0;
   int bad   = 0;

   // Instance A: DATA_W=8, DEPTH=4, cut-through
   logic       rst_a;
   logic [7:0] a_sd;
   logic       a_sk, a_sl, a_sv, a_sr;
   logic [7:0] a_md;
   logic       a_mk, a_ml, a_mv, a_mr;
   logic [2:0] a_occ, a_pkt;

   // Instance B: DATA_W=32, DEPTH=8, store-and-forward
   logic        rst_b;
   logic [31:0] b_sd;
   logic [3:0]  b_sk;
   logic        b_sl, b_sv, b_sr;
   logic [31:0] b_md;
   logic [3:0]  b_mk;
   logic        b_ml, b_mv, b_mr;
   logic [3:0]  b_occ, b_pkt;

   axis_packet_fifo #(.DATA_W(8), .DEPTH(4), .PACKET_MODE(0)) u_a (
      .aclk(aclk), .areset(rst_a),
      .s_axis_tdata(a_sd), .s_axis_tkeep(a_sk), .s_axis_tlast(a_sl),
      .s_axis_tvalid(a_sv), .s_axis_tready(a_sr),
      .m_axis_tdata(a_md), .m_axis_tkeep(a_mk), .m_axis_tlast(a_ml),
      .m_axis_tvalid(a_mv), .m_axis_tready(a_mr),
      .occupancy(a_occ), .pkt_count(a_pkt)
   );

   axis_packet_fifo #(.DATA_W(32), .DEPTH(8), .PACKET_MODE(1)) u_b (
      .aclk(aclk), .areset(rst_b),
      .s_axis_tdata(b_sd), .s_axis_tkeep(b_sk), .s_axis_tlast(b_sl),
      .s_axis_tvalid(b_sv), .s_axis_tready(b_sr),
      .m_axis_tdata(b_md), .m_axis_tkeep(b_mk), .m_axis_tlast(b_ml),
      .m_axis_tvalid(b_mv), .m_axis_tready(b_mr),
      .occupancy(b_occ), .pkt_count(b_pkt)
   );

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   beat_t qa[$];
   beat_t qb[$];
   int    b_nout = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard A: handshakes seen at negedge complete on the next posedge.
   always @(negedge aclk) begin
      beat_t e;
      if (!rst_a) begin
         if (a_sv && a_sr) qa.push_back({32'(a_sd), 4'(a_sk), a_sl});
         if (a_mv && a_mr) begin
            if (qa.size() == 0) begin
               chk("a_sb_extra", 32'd1, 32'd0);
            end else begin
               e = qa.pop_front();
               chk("a_sb_data", 32'(a_md), e.d);
               chk("a_sb_keep", 32'(a_mk), 32'(e.k));
               chk("a_sb_last", 32'(a_ml), 32'(e.l));
            end
         end
      end
   end

   // Scoreboard B plus output stability while stalled.
   logic  b_hold = 1'b0;
   beat_t b_prev;
   always @(negedge aclk) begin
      beat_t e;
      if (!rst_b) begin
         if (b_hold) begin
            chk("b_stable_v", 32'(b_mv), 32'd1);
            chk("b_stable_d", b_md, b_prev.d);
            chk("b_stable_kl", {27'd0, b_mk, b_ml}, {27'd0, b_prev.k, b_prev.l});
         end
         b_hold = b_mv & ~b_mr;
         b_prev = {b_md, b_mk, b_ml};
         if (b_sv && b_sr) qb.push_back({b_sd, b_sk, b_sl});
         if (b_mv && b_mr) begin
            b_nout++;
            if (qb.size() == 0) begin
               chk("b_sb_extra", 32'd1, 32'd0);
            end else begin
               e = qb.pop_front();
               chk("b_sb_data", b_md, e.d);
               chk("b_sb_keep", 32'(b_mk), 32'(e.k));
               chk("b_sb_last", 32'(b_ml), 32'(e.l));
            end
         end
      end
   end

   // Holds the beat on s_axis of B until accepted; call just after a posedge.
   task automatic send_b(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      b_sv = 1'b1; b_sd = d; b_sk = k; b_sl = l;
      do begin
         @(negedge aclk);
         acc = b_sr;
         @(posedge aclk);
         #1;
         n++;
      end while (!acc && n < 200);
      if (!acc) chk("b_send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain_b();
      for (int n = 0; n < 500 && (qb.size() != 0 || b_occ != 0); n++) @(posedge aclk);
      #1;
      chk("b_drain_q", 32'(qb.size()), 32'd0);
      chk("b_drain_occ", 32'(b_occ), 32'd0);
   endtask

   // Per-cycle vectors for A: inputs applied after a posedge, outputs
   // compared at the following negedge.
   typedef struct {
      logic       sv;
      logic [7:0] sd;
      logic       mr;
      logic       sr;
      logic       mv;
      logic [7:0] md;
      logic [2:0] occ;
   } vec_t;

   vec_t tv[17];

   function automatic vec_t mk(input logic sv, input logic [7:0] sd, input logic mr,
                               input logic sr, input logic mv, input logic [7:0] md,
                               input logic [2:0] occ);
      vec_t v;
      v = '{sv, sd, mr, sr, mv, md, occ};
      return v;
   endfunction

   bit rnd_done;

   initial begin
      // cut-through, ready high: one-cycle latency, occupancy stays at 1
      tv[0]  = mk(1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0);
      tv[1]  = mk(1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 3'd1);
      tv[2]  = mk(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 3'd1);
      tv[3]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd1);
      tv[4]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0);
      // ready low: fill to 4, tready drops; full does not accept on the pop cycle
      tv[5]  = mk(1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
      tv[6]  = mk(1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd1);
      tv[7]  = mk(1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd2);
      tv[8]  = mk(1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd3);
      tv[9]  = mk(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA1, 3'd4);
      tv[10] = mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA1, 3'd4);
      tv[11] = mk(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA2, 3'd3);
      tv[12] = mk(1'b1, 8'hA6, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd3);
      tv[13] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 3'd3);
      tv[14] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd2);
      tv[15] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA6, 3'd1);
      tv[16] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0);

      rst_a = 1'b1; rst_b = 1'b1;
      a_sd = '0; a_sk = 1'b1; a_sl = 1'b0; a_sv = 1'b0; a_mr = 1'b0;
      b_sd = '0; b_sk = '0;   b_sl = 1'b0; b_sv = 1'b0; b_mr = 1'b0;
      #1;
      chk("rst_a_sr", 32'(a_sr), 32'd0);
      chk("rst_a_mv", 32'(a_mv), 32'd0);
      chk("rst_a_md", 32'(a_md), 32'd0);
      chk("rst_b_sr", 32'(b_sr), 32'd0);
      chk("rst_b_occ", 32'(b_occ), 32'd0);
      repeat (2) @(posedge aclk);
      #2;
      rst_a = 1'b0; rst_b = 1'b0;
      #1;
      chk("rel_a_sr_before_edge", 32'(a_sr), 32'd0);
      @(posedge aclk);
      #1;
      chk("rel_a_sr_after_edge", 32'(a_sr), 32'd1);
      chk("rel_b_sr_after_edge", 32'(b_sr), 32'd1);

      // Table-driven cut-through and backpressure vectors on A
      for (int i = 0; i < 17; i++) begin
         @(posedge aclk);
         #1;
         a_sv = tv[i].sv; a_sd = tv[i].sd; a_mr = tv[i].mr;
         @(negedge aclk);
         chk($sformatf("vec%0d_sr", i), 32'(a_sr), 32'(tv[i].sr));
         chk($sformatf("vec%0d_mv", i), 32'(a_mv), 32'(tv[i].mv));
         chk($sformatf("vec%0d_occ", i), 32'(a_occ), 32'(tv[i].occ));
         if (tv[i].mv) chk($sformatf("vec%0d_md", i), 32'(a_md), 32'(tv[i].md));
      end

      // Reset mid-packet on A with three beats stored
      @(posedge aclk);
      #1;
      a_mr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a_sv = 1'b1; a_sd = 8'hC0 + 8'(k); a_sl = (k == 1);
         @(posedge aclk);
         #1;
      end
      a_sv = 1'b0; a_sl = 1'b0;
      @(negedge aclk);
      chk("a_pre_rst_occ", 32'(a_occ), 32'd3);
      chk("a_pre_rst_pkt", 32'(a_pkt), 32'd1);
      #2;
      rst_a = 1'b1;
      #1;
      qa.delete();
      chk("a_rst_mv", 32'(a_mv), 32'd0);
      chk("a_rst_occ", 32'(a_occ), 32'd0);
      chk("a_rst_pkt", 32'(a_pkt), 32'd0);
      chk("a_rst_sr", 32'(a_sr), 32'd0);
      chk("a_rst_mdata", {23'd0, a_md, a_ml}, 32'd0);
      @(posedge aclk);
      #2;
      rst_a = 1'b0;
      #1;
      chk("a_rel_sr_before", 32'(a_sr), 32'd0);
      @(posedge aclk);
      #1;
      chk("a_rel_sr_after", 32'(a_sr), 32'd1);
      a_mr = 1'b1;
      a_sv = 1'b1; a_sd = 8'hD1; a_sl = 1'b0;
      @(posedge aclk);
      #1;
      a_sd = 8'hD2; a_sl = 1'b1;
      @(posedge aclk);
      #1;
      a_sv = 1'b0; a_sl = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      chk("a_post_rst_q", 32'(qa.size()), 32'd0);
      chk("a_post_rst_occ", 32'(a_occ), 32'd0);

      // Store-and-forward: 3-beat packet held back until its TLAST arrives
      b_mr = 1'b1;
      for (int k = 0; k < 3; k++) begin
         b_sv = 1'b1; b_sd = 32'h3000_0000 + 32'(k); b_sk = 4'hF; b_sl = (k == 2);
         @(negedge aclk);
         chk("sf_mv_pre", 32'(b_mv), 32'd0);
         chk("sf_pkt_pre", 32'(b_pkt), 32'd0);
         chk("sf_sr_pre", 32'(b_sr), 32'd1);
         @(posedge aclk);
         #1;
      end
      b_sv = 1'b0; b_sl = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge aclk);
         chk("sf_mv_post", 32'(b_mv), 32'd1);
         chk("sf_pkt_post", 32'(b_pkt), 32'd1);
         chk("sf_last", 32'(b_ml), 32'(j == 2));
         @(posedge aclk);
         #1;
      end
      @(negedge aclk);
      chk("sf_mv_end", 32'(b_mv), 32'd0);
      chk("sf_pkt_end", 32'(b_pkt), 32'd0);
      @(posedge aclk);
      #1;

      // Oversized packet: 10 beats into DEPTH=8 must overflow-drain
      b_mr = 1'b0;
      for (int k = 0; k < 8; k++) send_b(32'h4000_0000 + 32'(k), 4'(k), 1'b0);
      b_sv = 1'b0;
      @(negedge aclk);
      chk("ovf_full_occ", 32'(b_occ), 32'd8);
      chk("ovf_full_sr", 32'(b_sr), 32'd0);
      chk("ovf_full_pkt", 32'(b_pkt), 32'd0);
      chk("ovf_full_mv", 32'(b_mv), 32'd0);
      @(posedge aclk);
      #1;
      @(negedge aclk);
      chk("ovf_drain_mv", 32'(b_mv), 32'd1);
      @(posedge aclk);
      #1;
      b_mr = 1'b1;
      send_b(32'h4000_0008, 4'h8, 1'b0);
      send_b(32'h4000_0009, 4'h0, 1'b1);
      b_sv = 1'b0; b_sl = 1'b0;
      drain_b();
      // Flag must be clear again: a lone non-TLAST beat is held back
      @(posedge aclk);
      #1;
      send_b(32'h5000_0000, 4'h1, 1'b0);
      b_sv = 1'b0;
      @(negedge aclk);
      chk("ovf_clear_mv", 32'(b_mv), 32'd0);
      chk("ovf_clear_occ", 32'(b_occ), 32'd1);
      @(posedge aclk);
      #1;
      send_b(32'h5000_0001, 4'h2, 1'b1);
      b_sv = 1'b0; b_sl = 1'b0;
      drain_b();

      // Random valid and oscillating ready, 200 beats
      b_nout = 0;
      rnd_done = 1'b0;
      @(posedge aclk);
      #1;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               while ($urandom_range(1, 0) == 0) begin
                  b_sv = 1'b0;
                  @(posedge aclk);
                  #1;
               end
               send_b($urandom(), 4'($urandom_range(15, 0)),
                      (i == 199) ? 1'b1 : ($urandom_range(3, 0) == 0));
            end
            b_sv = 1'b0; b_sl = 1'b0;
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               b_mr = 1'b0;
               repeat (2) begin @(posedge aclk); #1; end
               b_mr = 1'b1;
               repeat (6) begin @(posedge aclk); #1; end
            end
            b_mr = 1'b1;
         end
      join
      drain_b();
      chk("rnd_beat_count", 32'(b_nout), 32'd200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_packet_fifo.md
Name: axis_packet_fifo

Overview:
- Parametrised AXI4-Stream FIFO placed between a stream master and a stream slave (e.g. master and slave stream VIPs in the exdes bench).
- Generalises the plain 8-bit TDATA/TVALID/TREADY link: configurable width and depth, TKEEP/TLAST sideband, and an optional store-and-forward packet mode.
- Exposes occupancy and packet-count status for scoreboards and ready-pattern stress tests.

Parameters:
- DATA_W, 8: TDATA width in bits; multiple of 8; TKEEP width is DATA_W/8.
- DEPTH, 16: entries; power of 2, ≥ 2.
- PACKET_MODE, 0: 0 = cut-through; 1 = store-and-forward (output only whole packets).

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- s_axis_tdata  in  DATA_W  input data
- s_axis_tkeep  in  DATA_W/8  input byte enables
- s_axis_tlast  in  1  input end of packet
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  DATA_W  output data
- m_axis_tkeep  out  DATA_W/8  output byte enables
- m_axis_tlast  out  1  output end of packet
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- occupancy  out  $clog2(DEPTH)+1  stored beats
- pkt_count  out  $clog2(DEPTH)+1  complete packets stored (TLAST beats in FIFO)

Behaviour:
- Reset:
  - areset asserted clears read/write pointers, occupancy, pkt_count, output valid register and the overflow flag immediately.
  - While areset is high, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0.
  - s_axis_tready rises on the first aclk edge after areset falls.
  - Reset mid-packet discards all stored data; no partial-packet recovery.
- Storage and handshakes:
  - Storage is DEPTH entries of {tdata, tkeep, tlast}.
  - Push occurs when s_axis_tvalid & s_axis_tready.
  - s_axis_tready = ~full, decoded from registered state only. It never depends combinationally on m_axis_tready, so a full FIFO does not accept in the cycle a pop frees space.
  - Pop occurs when m_axis_tvalid & m_axis_tready.
  - m_axis_* are fed from a registered output stage that counts toward occupancy.
  - m_axis_tvalid, once high, stays high with stable data until the handshake completes (AXI4-Stream rule).
- Latency, cut-through (PACKET_MODE=0):
  - A beat accepted at edge N is visible on m_axis at edge N+1 when the FIFO was empty.
  - Sustained throughput is 1 beat/cycle with simultaneous push and pop at any non-full occupancy.
- Store-and-forward (PACKET_MODE=1):
  - pkt_count increments on a push with tlast=1 and decrements on a pop with tlast=1. Simultaneous increment and decrement leaves it unchanged.
  - m_axis_tvalid is presented only while pkt_count>0 or the overflow flag is set.
  - When the last beat is accepted at edge N, the first beat of that packet is valid at edge N+1 at the earliest.
- Overflow (packet larger than DEPTH, PACKET_MODE=1):
  - If full and pkt_count=0, the overflow flag sets and the FIFO drains in cut-through until a beat with tlast=1 is popped, then the flag clears.
  - No data is dropped, which prevents deadlock.
- Pointers:
  - Pointers are $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - Wrap-around is natural binary rollover.
  - occupancy = wptr - rptr (modulo), range 0..DEPTH inclusive.
- Sideband pass-through:
  - TKEEP and TLAST pass unmodified. Beats with TKEEP=0 are stored and forwarded, not filtered.

Test Plan:
1. DATA_W=8, DEPTH=4, PACKET_MODE=0, m_axis_tready=1; push 0x11,0x22,0x33 on consecutive cycles → each appears on m_axis one cycle later, in order; occupancy never exceeds 1.
2. Same config, m_axis_tready=0; push 6 beats → s_axis_tready drops after 4 accepts, occupancy=4; raise m_axis_tready → 4 beats drain in order, then the remaining 2 are accepted and delivered in order.
3. PACKET_MODE=1, DEPTH=8; send a 3-beat packet (tlast on beat 3) with m_axis_tready=1 → m_axis_tvalid stays 0 until the cycle after beat 3 is accepted, then 3 consecutive beats; pkt_count goes 0→1→0.
4. PACKET_MODE=1, DEPTH=4; send a 6-beat packet → full with pkt_count=0 triggers the overflow flag; all 6 beats emerge in order with tlast only on beat 6; flag clears after the tlast pop.
5. DATA_W=32; random TVALID on the input and OSC pattern on m_axis_tready (low 2, high 6), 200 beats with random TKEEP/TLAST → output sequence identical to input; no beat lost or duplicated; m_axis data stable while tvalid & ~tready.
6. Assert areset with occupancy=3 mid-packet → m_axis_tvalid=0, occupancy=0, pkt_count=0 immediately; s_axis_tready=1 one edge after release; a new packet passes correctly.
